// File: rtl/freq_bcd_conv.sv
// rtl/freq_bcd_conv.sv - sequential binary-to-BCD converter for the frequency display
// Double-dabble over IN_W clocks; emits packed BCD, a significant-digit count and a valid pulse.
module freq_bcd_conv #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [IN_W-1:0]     frequency_i,
  input  logic                refresh_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [3:0]          digits_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                  state;
  logic [IN_W-1:0]         last_cap;
  logic [IN_W-1:0]         shreg;
  logic [BCD_W-1:0]        acc;
  logic [BCD_W-1:0]        acc_adj;
  logic [BCD_W+IN_W-1:0]   shifted;
  logic [CNT_W-1:0]        iter;
  logic                    pending;
  logic                    changed;
  logic [3:0]              sig_digits;

  assign changed = (frequency_i != last_cap) || refresh_i;

  // Add-3 correction stays within 4 bits: a nibble >= 5 becomes at most 12.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {acc_adj, shreg} << 1;

  always_comb begin
    sig_digits = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        sig_digits = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      last_cap <= '0;
      shreg    <= '0;
      acc      <= '0;
      iter     <= '0;
      pending  <= 1'b0;
      bcd_o    <= '0;
      digits_o <= 4'd1;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (changed || pending) begin
            shreg    <= frequency_i;
            last_cap <= frequency_i;
            acc      <= '0;
            iter     <= '0;
            pending  <= 1'b0;
            busy_o   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= shifted[BCD_W+IN_W-1:IN_W];
          shreg <= shifted[IN_W-1:0];
          iter  <= iter + CNT_W'(1);
          // Changes seen while busy collapse into one reconversion afterwards.
          if (changed) begin
            pending <= 1'b1;
          end
          if (iter == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_o    <= acc;
          digits_o <= sig_digits;
          valid_o  <= 1'b1;
          busy_o   <= 1'b0;
          if (changed) begin
            pending <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/freq_bcd_conv.md
Name: freq_bcd_conv

Overview:
- Sequential binary-to-BCD converter for the 32-bit frequency word produced by the frequency-select logic (frequency_o).
- Detects value changes and runs an iterative shift-add-3 (double-dabble) conversion.
- Presents packed BCD digits plus a significant-digit count to the LCD text/overlay renderer.
- One conversion in flight at a time; a valid pulse marks each new result.

Parameters:
- IN_W, 32: width of binary input word.
- DIGITS, 10: number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W - 1.

Ports:
- clk_i  input  1  system clock, 50 MHz.
- rst_n_i  input  1  reset, asynchronous, active-low.
- frequency_i  input  IN_W  binary frequency word, Hz.
- refresh_i  input  1  single-cycle pulse; forces reconversion of the current frequency_i.
- bcd_o  output  4*DIGITS  packed BCD; bits [3:0] are the units digit.
- digits_o  output  4  count of significant digits, 1..DIGITS; a value of 0 reports 1.
- valid_o  output  1  one-cycle pulse when bcd_o/digits_o take a new result.
- busy_o  output  1  high while a conversion is in progress.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values:
  - bcd_o = 0, digits_o = 1, valid_o = 0, busy_o = 0.
  - Internal last-captured word = 0, pending = 0, state = IDLE.
- States:
  - IDLE: at each edge, start when (frequency_i != last_captured) or refresh_i or pending.
    - On start: capture frequency_i into the shift register and last_captured; clear the BCD accumulator and pending; go to SHIFT; busy_o = 1 from the next cycle.
  - SHIFT: IN_W iterations, one per edge.
    - Each iteration: every BCD nibble >= 5 gets +3; then the combined {bcd, bin} shifts left by one, MSB of bin entering bit 0 of bcd.
    - The iteration counter counts 0..IN_W-1; after the last iteration go to DONE.
  - DONE: one edge.
    - Register the accumulator into bcd_o.
    - Compute digits_o = index of the highest nonzero nibble + 1 (1 if all nibbles are zero).
    - Pulse valid_o for exactly the following cycle; clear busy_o; return to IDLE.
- Latency: capture edge E0, shift edges E1..E32, output edge E33. valid_o is high in the cycle after E33, i.e. 33 clocks after capture.
- Back-to-back conversions: the earliest next capture is the edge after valid_o rises, so the minimum period is 34 clocks.
- Change or refresh during SHIFT/DONE:
  - The current conversion completes and still emits valid_o with the old value.
  - pending is set if (frequency_i != last_captured) or refresh_i is seen in any cycle while busy.
  - The next IDLE edge starts a new conversion with frequency_i as sampled at that edge. Multiple changes while busy collapse into one reconversion.
- Outputs hold between valid pulses. bcd_o never shows partial results.
- Reset mid-conversion: all outputs return to reset values immediately and asynchronously. No valid_o is emitted for the aborted conversion.
- After reset, frequency_i == 0 does not trigger a conversion because last_captured = 0. A nonzero frequency_i triggers one on the first edge after release.
- Adder/width rules:
  - Nibble add-3 is 4-bit with no carry-out: after the >= 5 check the value is at most 12.
  - The shift register is IN_W bits; the BCD accumulator is 4*DIGITS bits.
  - With the default parameters the MSB shifted out of the top nibble is always 0, so no overflow flag is provided.

Test Plan:
- Reset, then frequency_i = 0, no refresh for 100 clocks -> valid_o never asserts; bcd_o = 0, digits_o = 1, busy_o = 0.
- frequency_i = 1000 after reset -> busy_o high for 33 cycles; valid_o pulses once, 33 clocks after capture; bcd_o = 40'h00_0000_1000, digits_o = 4.
- frequency_i = 32'hFFFF_FFFF -> bcd_o = 40'h42_9496_7295, digits_o = 10. Then frequency_i = 7 -> bcd_o = 40'h7, digits_o = 1.
- During a conversion of 1234:
  - frequency_i changes to 5678 at SHIFT iteration 10, then to 9999 at iteration 20.
  - Required: first valid_o carries 0x1234, digits_o = 4.
  - Second valid_o, 34 clocks later, carries 0x9999. There is no result for 5678 and no third pulse.
- frequency_i held at 250 with a refresh_i pulse while idle -> one additional valid_o with bcd_o = 0x250, digits_o = 3. A refresh_i pulse while busy -> exactly one extra reconversion.
- rst_n_i asserted low mid-SHIFT (asynchronously, between edges) -> bcd_o = 0, digits_o = 1, busy_o = 0, valid_o = 0 immediately.
  - After release with frequency_i = 50 -> a fresh conversion gives bcd_o = 0x50, digits_o = 2.
